// File: rtl/oled_spi_sink_if.sv
// SPI-side pins of the SSD1306 link: the driver owns all four wires.
interface oled_spi_sink_if;
  logic sclk;
  logic sdin;
  logic dc;
  logic res_n;

  modport master (output sclk, output sdin, output dc, output res_n);
  modport slave  (input sclk, input sdin, input dc, input res_n);
endinterface

// File: rtl/oled_spi_sink.sv
// SSD1306-style SPI receiver: deserializes the driver's byte stream, decodes the command
// subset it uses, tracks page/column addressing and emits GDDRAM write strobes.
module oled_spi_sink #(
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  oled_spi_sink_if.slave                spi,
  output logic                          mem_we,
  output logic [$clog2(COLS*PAGES)-1:0] mem_addr,
  output logic [7:0]                    mem_wdata,
  output logic                          disp_on,
  output logic                          entire_on,
  output logic                          invert,
  output logic                          seg_remap,
  output logic                          com_scan,
  output logic [7:0]                    contrast,
  output logic [1:0]                    addr_mode,
  output logic                          cmd_err
);

  localparam int unsigned AW = $clog2(COLS * PAGES);
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;

  typedef enum logic [1:0] {StCmd, StArg1, StArg2} state_e;

  // Synchronizer: bit 0 sclk, 1 sdin, 2 dc, 3 res_n.
  logic [3:0] sync_q [SYNC_STAGES];
  logic       sclk_s, sdin_s, dc_s, res_s;
  logic       sclk_prev_q;
  logic       sclk_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 4'b0000;
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {spi.res_n, spi.dc, spi.sdin, spi.sclk};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sync_q[SYNC_STAGES-1][0];
  assign sdin_s    = sync_q[SYNC_STAGES-1][1];
  assign dc_s      = sync_q[SYNC_STAGES-1][2];
  assign res_s     = sync_q[SYNC_STAGES-1][3];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Deserializer: the bit counter is the only framing, res_n low realigns it.
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;
  logic       byte_rdy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_q     <= 8'd0;
      byte_dc_q  <= 1'b0;
      byte_rdy_q <= 1'b0;
    end else if (!res_s) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_q     <= 8'd0;
      byte_dc_q  <= 1'b0;
      byte_rdy_q <= 1'b0;
    end else begin
      byte_rdy_q <= 1'b0;
      if (sclk_rise) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q     <= {shift_q, sdin_s};
          byte_dc_q  <= dc_s;
          byte_rdy_q <= 1'b1;
        end
      end
    end
  end

  // Decoder and addressing state.
  state_e        state_q;
  logic [7:0]    op_q;
  logic [7:0]    arg_q;
  logic [CW-1:0] col_q, col_start_q, col_end_q;
  logic [PW-1:0] page_q, page_start_q, page_end_q;

  function automatic logic [CW-1:0] clamp_col(input int unsigned v);
    return (v > COLS - 1) ? CW'(COLS - 1) : CW'(v);
  endfunction

  function automatic logic [PW-1:0] clamp_page(input int unsigned v);
    return (v > PAGES - 1) ? PW'(PAGES - 1) : PW'(v);
  endfunction

  // Reaching the window end reloads the start, which also handles start > end.
  function automatic logic [CW-1:0] adv_col(input logic [CW-1:0] v);
    if (v == col_end_q) return col_start_q;
    return CW'((32'(v) + 32'd1) % COLS);
  endfunction

  function automatic logic [PW-1:0] adv_page(input logic [PW-1:0] v);
    if (v == page_end_q) return page_start_q;
    return PW'((32'(v) + 32'd1) % PAGES);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StCmd;
      op_q         <= 8'd0;
      arg_q        <= 8'd0;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'd0;
      disp_on      <= 1'b0;
      entire_on    <= 1'b0;
      invert       <= 1'b0;
      seg_remap    <= 1'b0;
      com_scan     <= 1'b0;
      contrast     <= 8'h7F;
      addr_mode    <= 2'b10;
      cmd_err      <= 1'b0;
    end else if (!res_s) begin
      state_q      <= StCmd;
      op_q         <= 8'd0;
      arg_q        <= 8'd0;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'd0;
      disp_on      <= 1'b0;
      entire_on    <= 1'b0;
      invert       <= 1'b0;
      seg_remap    <= 1'b0;
      com_scan     <= 1'b0;
      contrast     <= 8'h7F;
      addr_mode    <= 2'b10;
      cmd_err      <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cmd_err <= 1'b0;
      if (byte_rdy_q) begin
        if (byte_dc_q) begin
          // A data byte abandons any half-received command and is still written.
          if (state_q != StCmd) cmd_err <= 1'b1;
          state_q   <= StCmd;
          mem_we    <= 1'b1;
          mem_addr  <= AW'(32'(page_q) * COLS + 32'(col_q));
          mem_wdata <= byte_q;
          case (addr_mode)
            2'b00: begin
              if (col_q == col_end_q) page_q <= adv_page(page_q);
              col_q <= adv_col(col_q);
            end
            2'b01: begin
              if (page_q == page_end_q) col_q <= adv_col(col_q);
              page_q <= adv_page(page_q);
            end
            default: col_q <= adv_col(col_q);
          endcase
        end else begin
          unique case (state_q)
            StCmd: begin
              case (byte_q) inside
                8'hAE, 8'hAF: disp_on   <= byte_q[0];
                8'hA4, 8'hA5: entire_on <= byte_q[0];
                8'hA6, 8'hA7: invert    <= byte_q[0];
                8'hA0, 8'hA1: seg_remap <= byte_q[0];
                8'hC0, 8'hC8: com_scan  <= byte_q[3];
                [8'h00:8'h0F]: col_q <= clamp_col((32'(col_q) & 32'h70) | 32'(byte_q[3:0]));
                [8'h10:8'h1F]: col_q <= clamp_col((32'(col_q) & 32'h0F) | (32'(byte_q[2:0]) << 4));
                [8'hB0:8'hB7]: page_q <= clamp_page(32'(byte_q[2:0]));
                [8'h40:8'h7F]: begin
                end
                8'h81, 8'h20, 8'h8D, 8'hD9, 8'hDA, 8'hA8, 8'hD3, 8'hD5, 8'hDB,
                8'h21, 8'h22: begin
                  op_q    <= byte_q;
                  state_q <= StArg1;
                end
                default: cmd_err <= 1'b1;
              endcase
            end
            StArg1: begin
              state_q <= StCmd;
              case (op_q)
                8'h81: contrast <= byte_q;
                8'h20: begin
                  if (byte_q[1:0] == 2'b11) cmd_err <= 1'b1;
                  else addr_mode <= byte_q[1:0];
                end
                8'h21, 8'h22: begin
                  arg_q   <= byte_q;
                  state_q <= StArg2;
                end
                default: begin
                end
              endcase
            end
            StArg2: begin
              state_q <= StCmd;
              if (op_q == 8'h21) begin
                col_start_q <= clamp_col(32'(arg_q));
                col_end_q   <= clamp_col(32'(byte_q));
                col_q       <= clamp_col(32'(arg_q));
              end else begin
                page_start_q <= clamp_page(32'(arg_q));
                page_end_q   <= clamp_page(32'(byte_q));
                page_q       <= clamp_page(32'(arg_q));
              end
            end
            default: state_q <= StCmd;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: command table, directed corner sequences and a
// randomized byte stream compared against a command-level reference model.
module tb_oled_spi_sink;
  localparam int unsigned COLS        = 128;
  localparam int unsigned PAGES       = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_we, disp_on, entire_on, invert, seg_remap, com_scan, cmd_err;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata, contrast;
  logic [1:0] addr_mode;

  oled_spi_sink_if spi ();

  oled_spi_sink #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .spi(spi), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .disp_on(disp_on), .entire_on(entire_on), .invert(invert),
    .seg_remap(seg_remap), .com_scan(com_scan), .contrast(contrast), .addr_mode(addr_mode),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Write/error monitor.
  typedef struct {int addr; int data;} wr_t;
  wr_t got_q[$];
  int  err_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (mem_we) begin
      wr_t w;
      w.addr = int'(mem_addr);
      w.data = int'(mem_wdata);
      got_q.push_back(w);
    end
    if (cmd_err) err_cnt++;
  end

  // Command-level reference model.
  int  m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_contrast;
  int  m_disp, m_ent, m_inv, m_seg, m_com, exp_err;
  int  pend[$];
  wr_t exp_q[$];

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int adv(input int v, input int s, input int e, input int m);
    return (v == e) ? s : (v + 1) % m;
  endfunction

  function automatic int nargs(input int op);
    if (op inside {'h81, 'h20, 'h8D, 'hD9, 'hDA, 'hA8, 'hD3, 'hD5, 'hDB}) return 1;
    if (op == 'h21 || op == 'h22) return 2;
    if (op <= 'h1F || (op >= 'h40 && op <= 'h7F) || (op >= 'hB0 && op <= 'hB7)) return 0;
    if (op inside {'hAE, 'hAF, 'hA4, 'hA5, 'hA6, 'hA7, 'hA0, 'hA1, 'hC0, 'hC8}) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_mode = 2; m_contrast = 'h7F;
    m_disp = 0; m_ent = 0; m_inv = 0; m_seg = 0; m_com = 0; exp_err = 0;
    pend.delete();
    exp_q.delete();
  endtask

  task automatic model_apply();
    int op = pend[0];
    if (op <= 'h0F) m_col = lim((m_col & 'h70) | (op & 'hF), COLS - 1);
    else if (op <= 'h1F) m_col = lim((m_col & 'hF) | ((op & 7) << 4), COLS - 1);
    else if (op >= 'hB0 && op <= 'hB7) m_page = lim(op & 7, PAGES - 1);
    else if (op == 'hAE || op == 'hAF) m_disp = op & 1;
    else if (op == 'hA4 || op == 'hA5) m_ent = op & 1;
    else if (op == 'hA6 || op == 'hA7) m_inv = op & 1;
    else if (op == 'hA0 || op == 'hA1) m_seg = op & 1;
    else if (op == 'hC0 || op == 'hC8) m_com = (op >> 3) & 1;
    else if (op == 'h81) m_contrast = pend[1];
    else if (op == 'h20) begin
      if ((pend[1] & 3) == 3) exp_err++;
      else m_mode = pend[1] & 3;
    end else if (op == 'h21) begin
      m_cs = lim(pend[1], COLS - 1); m_ce = lim(pend[2], COLS - 1); m_col = m_cs;
    end else if (op == 'h22) begin
      m_ps = lim(pend[1], PAGES - 1); m_pe = lim(pend[2], PAGES - 1); m_page = m_ps;
    end
  endtask

  task automatic model_byte(input int b, input bit d);
    if (d) begin
      wr_t w;
      bit  cwrap, pwrap;
      if (pend.size() > 0) begin
        exp_err++;
        pend.delete();
      end
      w.addr = m_page * COLS + m_col;
      w.data = b;
      exp_q.push_back(w);
      cwrap = (m_col == m_ce);
      pwrap = (m_page == m_pe);
      if (m_mode == 0) begin
        if (cwrap) m_page = adv(m_page, m_ps, m_pe, PAGES);
        m_col = adv(m_col, m_cs, m_ce, COLS);
      end else if (m_mode == 1) begin
        if (pwrap) m_col = adv(m_col, m_cs, m_ce, COLS);
        m_page = adv(m_page, m_ps, m_pe, PAGES);
      end else begin
        m_col = adv(m_col, m_cs, m_ce, COLS);
      end
    end else begin
      pend.push_back(b);
      if (nargs(pend[0]) < 0) begin
        exp_err++;
        pend.delete();
      end else if (pend.size() == nargs(pend[0]) + 1) begin
        model_apply();
        pend.delete();
      end
    end
  endtask

  // Pin-level stimulus: sclk period is 4 clk cycles.
  task automatic send_byte(input logic [7:0] b, input logic d);
    @(negedge clk);
    spi.dc = d;
    for (int i = 7; i >= 0; i--) begin
      spi.sdin = b[i];
      #20 spi.sclk = 1'b1;
      #20 spi.sclk = 1'b0;
    end
  endtask

  // Sends a byte, then counts clk edges from the 8th sclk rise until mem_we shows up.
  task automatic send_byte_wait(input logic [7:0] b, input logic d, output int lat);
    @(negedge clk);
    spi.dc = d;
    for (int i = 7; i >= 1; i--) begin
      spi.sdin = b[i];
      #20 spi.sclk = 1'b1;
      #20 spi.sclk = 1'b0;
    end
    spi.sdin = b[0];
    #20 spi.sclk = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (mem_we) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    spi.sclk = 1'b0; spi.sdin = 1'b0; spi.dc = 1'b0; spi.res_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();
    err_cnt = 0;
    model_reset();
  endtask

  task automatic chk_wr(input string name, input int idx, input int addr, input int data);
    if (idx < got_q.size()) begin
      check({name, "_addr"}, got_q[idx].addr, addr);
      check({name, "_data"}, got_q[idx].data, data);
    end else begin
      check({name, "_present"}, got_q.size(), idx + 1);
    end
  endtask

  task automatic chk_regs(input string name, input int con, input int dsp, input int ent,
                          input int inv, input int seg, input int com, input int mode);
    check({name, "_contrast"}, int'(contrast), con);
    check({name, "_disp_on"}, int'(disp_on), dsp);
    check({name, "_entire_on"}, int'(entire_on), ent);
    check({name, "_invert"}, int'(invert), inv);
    check({name, "_seg_remap"}, int'(seg_remap), seg);
    check({name, "_com_scan"}, int'(com_scan), com);
    check({name, "_addr_mode"}, int'(addr_mode), mode);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       d;
    int         con, dsp, ent, inv, seg, com, mode, err;
  } vec_t;

  typedef struct {logic [7:0] b; logic d;} item_t;

  initial begin
    vec_t  vt[$];
    item_t items[$];
    int    lat, e0, bad;

    vt.push_back('{8'h81, 1'b0, 'h7F, 0, 0, 0, 0, 0, 2, 0});
    vt.push_back('{8'hF1, 1'b0, 'hF1, 0, 0, 0, 0, 0, 2, 0});
    vt.push_back('{8'hAF, 1'b0, 'hF1, 1, 0, 0, 0, 0, 2, 0});
    vt.push_back('{8'hA5, 1'b0, 'hF1, 1, 1, 0, 0, 0, 2, 0});
    vt.push_back('{8'hA7, 1'b0, 'hF1, 1, 1, 1, 0, 0, 2, 0});
    vt.push_back('{8'hA1, 1'b0, 'hF1, 1, 1, 1, 1, 0, 2, 0});
    vt.push_back('{8'hC8, 1'b0, 'hF1, 1, 1, 1, 1, 1, 2, 0});
    vt.push_back('{8'h20, 1'b0, 'hF1, 1, 1, 1, 1, 1, 2, 0});
    vt.push_back('{8'h01, 1'b0, 'hF1, 1, 1, 1, 1, 1, 1, 0});
    vt.push_back('{8'h20, 1'b0, 'hF1, 1, 1, 1, 1, 1, 1, 0});
    vt.push_back('{8'h03, 1'b0, 'hF1, 1, 1, 1, 1, 1, 1, 1});
    vt.push_back('{8'hE5, 1'b0, 'hF1, 1, 1, 1, 1, 1, 1, 1});
    vt.push_back('{8'hAE, 1'b0, 'hF1, 0, 1, 1, 1, 1, 1, 0});
    vt.push_back('{8'hA4, 1'b0, 'hF1, 0, 0, 1, 1, 1, 1, 0});
    vt.push_back('{8'hA6, 1'b0, 'hF1, 0, 0, 0, 1, 1, 1, 0});
    vt.push_back('{8'hA0, 1'b0, 'hF1, 0, 0, 0, 0, 1, 1, 0});
    vt.push_back('{8'hC0, 1'b0, 'hF1, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'h8D, 1'b0, 'hF1, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'h14, 1'b0, 'hF1, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'h20, 1'b0, 'hF1, 0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'h02, 1'b0, 'hF1, 0, 0, 0, 0, 0, 2, 0});

    // Reset state.
    do_reset();
    chk_regs("reset", 'h7F, 0, 0, 0, 0, 0, 2);
    check("reset_mem_we", int'(mem_we), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_mem_wdata", int'(mem_wdata), 0);
    check("reset_cmd_err", int'(cmd_err), 0);

    // Command table.
    foreach (vt[i]) begin
      e0 = err_cnt;
      send_byte(vt[i].b, vt[i].d);
      settle();
      chk_regs($sformatf("vec%0d", i), vt[i].con, vt[i].dsp, vt[i].ent, vt[i].inv,
               vt[i].seg, vt[i].com, vt[i].mode);
      check($sformatf("vec%0d_cmd_err", i), err_cnt - e0, vt[i].err);
    end
    check("table_no_writes", got_q.size(), 0);

    // Horizontal window over the whole screen, page end clamped.
    do_reset();
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    for (int i = 0; i < 513; i++) send_byte(8'(i), 1);
    settle();
    check("horiz_count", got_q.size(), 513);
    bad = 0;
    for (int i = 0; i < 513 && i < got_q.size(); i++)
      if (got_q[i].addr != i % 512 || got_q[i].data != (i & 'hFF)) bad++;
    check("horiz_seq_bad", bad, 0);
    chk_wr("horiz_wrap", 512, 0, 0);
    check("horiz_err", err_cnt, 0);

    // Vertical mode with clamped page window and a single-column window.
    do_reset();
    send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h07, 0);
    send_byte(8'h21, 0); send_byte(8'h05, 0); send_byte(8'h05, 0);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    settle();
    chk_wr("vert0", 0, 133, 'h11);
    chk_wr("vert1", 1, 261, 'h22);
    chk_wr("vert2", 2, 389, 'h33);
    chk_wr("vert3", 3, 133, 'h44);

    // Page mode addressing and the 127 -> 0 column wrap.
    do_reset();
    send_byte(8'hB2, 0); send_byte(8'h05, 0); send_byte(8'h13, 0);
    send_byte(8'hA1, 1); send_byte(8'hA2, 1);
    send_byte(8'h17, 0); send_byte(8'h0F, 0);
    send_byte(8'hB1, 1); send_byte(8'hB2, 1);
    settle();
    chk_wr("page0", 0, 309, 'hA1);
    chk_wr("page1", 1, 310, 'hA2);
    chk_wr("colwrap0", 2, 383, 'hB1);
    chk_wr("colwrap1", 3, 256, 'hB2);

    // Data byte during an argument abandons the command.
    do_reset();
    send_byte(8'h81, 0); send_byte(8'h55, 1);
    settle();
    check("abandon_err", err_cnt, 1);
    check("abandon_contrast", int'(contrast), 'h7F);
    check("abandon_count", got_q.size(), 1);
    chk_wr("abandon_wr", 0, 0, 'h55);

    // res_n mid-byte resynchronizes framing and resets all state.
    do_reset();
    send_byte(8'h81, 0); send_byte(8'h33, 0); send_byte(8'hA7, 0); send_byte(8'hB3, 0);
    @(negedge clk);
    spi.dc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spi.sdin = i[0];
      #20 spi.sclk = 1'b1;
      #20 spi.sclk = 1'b0;
    end
    @(negedge clk);
    spi.res_n = 1'b0;
    repeat (10) @(negedge clk);
    spi.res_n = 1'b1;
    repeat (4) @(negedge clk);
    e0 = err_cnt;
    send_byte(8'hAF, 0);
    settle();
    chk_regs("resn", 'h7F, 1, 0, 0, 0, 0, 2);
    check("resn_err", err_cnt - e0, 0);
    send_byte(8'h5A, 1);
    settle();
    check("resn_count", got_q.size(), 1);
    chk_wr("resn_wr", 0, 0, 'h5A);

    // Unknown opcode followed by a valid one.
    do_reset();
    send_byte(8'hE5, 0);
    settle();
    check("unknown_err", err_cnt, 1);
    send_byte(8'hAF, 0);
    settle();
    check("unknown_then_af", int'(disp_on), 1);
    check("unknown_err_once", err_cnt, 1);

    // Write latency, then asynchronous reset while mem_we is high.
    do_reset();
    send_byte_wait(8'h3C, 1, lat);
    spi.sclk = 1'b0;
    check("latency", lat, SYNC_STAGES + 2);
    check("latency_addr", int'(mem_addr), 0);
    check("latency_data", int'(mem_wdata), 'h3C);
    send_byte(8'h81, 0); send_byte(8'h40, 0); send_byte(8'hAF, 0);
    send_byte_wait(8'h99, 1, lat);
    rst = 1'b0;
    #1;
    spi.sclk = 1'b0;
    check("rst_mid_mem_we", int'(mem_we), 0);
    check("rst_mid_addr", int'(mem_addr), 0);
    check("rst_mid_wdata", int'(mem_wdata), 0);
    chk_regs("rst_mid", 'h7F, 0, 0, 0, 0, 0, 2);
    rst = 1'b1;

    // Randomized stream against the reference model.
    do_reset();
    for (int n = 0; n < 160; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 45) begin
        items.push_back('{8'($urandom_range(0, 255)), 1'b1});
      end else if (r < 75) begin
        int k = $urandom_range(0, 9);
        case (k)
          0: items.push_back('{8'(8'hB0 + $urandom_range(0, 7)), 1'b0});
          1: items.push_back('{8'($urandom_range(0, 31)), 1'b0});
          2: begin
            items.push_back('{8'h20, 1'b0});
            items.push_back('{8'($urandom_range(0, 3)), 1'b0});
          end
          3: begin
            items.push_back('{8'h21, 1'b0});
            items.push_back('{8'($urandom_range(0, 255)), 1'b0});
            items.push_back('{8'($urandom_range(0, 255)), 1'b0});
          end
          4: begin
            items.push_back('{8'h22, 1'b0});
            items.push_back('{8'($urandom_range(0, 7)), 1'b0});
            items.push_back('{8'($urandom_range(0, 7)), 1'b0});
          end
          5: begin
            items.push_back('{8'h81, 1'b0});
            items.push_back('{8'($urandom_range(0, 255)), 1'b0});
          end
          6: items.push_back('{8'(8'hAE + $urandom_range(0, 1)), 1'b0});
          7: items.push_back('{8'(8'hA4 + $urandom_range(0, 3)), 1'b0});
          8: items.push_back('{($urandom_range(0, 1) != 0) ? 8'hC8 : 8'hC0, 1'b0});
          default: items.push_back('{8'(8'h40 + $urandom_range(0, 63)), 1'b0});
        endcase
      end else if (r < 85) begin
        items.push_back('{8'($urandom_range(0, 255)), 1'b0});
      end else begin
        items.push_back('{($urandom_range(0, 1) != 0) ? 8'h21 : 8'h22, 1'b0});
        if ($urandom_range(0, 1) != 0) items.push_back('{8'($urandom_range(0, 3)), 1'b0});
        items.push_back('{8'($urandom_range(0, 255)), 1'b1});
      end
    end
    foreach (items[i]) begin
      send_byte(items[i].b, items[i].d);
      model_byte(int'(items[i].b), items[i].d);
    end
    settle();
    check("rand_count", got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) bad++;
    check("rand_writes_bad", bad, 0);
    check("rand_err", err_cnt, exp_err);
    chk_regs("rand", m_contrast, m_disp, m_ent, m_inv, m_seg, m_com, m_mode);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
